// File: rtl/csi_rx_raw10_unpacker.sv
// RAW10 unpacker for a CSI-2 receiver: packs 16-bit payload beats into groups of four 10-bit pixels.
// It also produces the line/frame event pulses, checks line length and counts lines per frame.
module csi_rx_raw10_unpacker #(
  parameter int LINE_WIDTH = 1920
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [15:0] payload,
  input  logic        payload_valid,
  input  logic        in_line,
  input  logic        in_frame,
  output logic [39:0] pixel_data,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        line_end,
  output logic        frame_start,
  output logic        frame_end,
  output logic        line_err,
  output logic [15:0] line_count
);

  localparam logic [15:0] LINE_PIX = 16'(LINE_WIDTH);

  logic [7:0]  byte_q [6];
  logic [7:0]  work   [6];
  logic [7:0]  byte_nxt [6];
  logic [2:0]  fill_q, fill_base, fill_sum, fill_nxt;
  logic [15:0] pix_cnt_q, pix_base, pix_nxt;
  logic        in_line_q, in_frame_q, line_act_q, line_act_nxt;
  logic        line_rise, line_fall, frame_rise, frame_fall;
  logic        line_go, accept, emit, line_done, err;
  logic [39:0] group;

  always_comb begin
    line_rise  = in_line & ~in_line_q;
    line_fall  = ~in_line & in_line_q;
    frame_rise = in_frame & ~in_frame_q;
    frame_fall = ~in_frame & in_frame_q;

    // A line only counts if it began while a frame was already open.
    line_go   = line_rise ? in_frame_q : line_act_q;
    accept    = enable & payload_valid & in_line & line_go;
    fill_base = line_rise ? 3'd0 : fill_q;
    pix_base  = line_rise ? 16'd0 : pix_cnt_q;
    fill_sum  = fill_base + 3'd2;
    emit      = accept && (fill_sum >= 3'd5);

    for (int i = 0; i < 6; i++) begin
      work[i] = byte_q[i];
      if (accept && (3'(i) == fill_base))
        work[i] = payload[15:8];
      else if (accept && (3'(i) == fill_sum - 3'd1))
        work[i] = payload[7:0];
    end

    for (int i = 0; i < 6; i++)
      byte_nxt[i] = work[i];
    if (emit)
      byte_nxt[0] = work[5];

    fill_nxt = fill_base;
    if (accept)
      fill_nxt = emit ? (fill_sum - 3'd5) : fill_sum;
    if (line_fall)
      fill_nxt = 3'd0;

    pix_nxt = pix_base;
    if (emit)
      pix_nxt = (pix_base > 16'hFFFB) ? 16'hFFFF : pix_base + 16'd4;

    group = {work[3], work[4][7:6], work[2], work[4][5:4],
             work[1], work[4][3:2], work[0], work[4][1:0]};

    line_done = line_fall & line_act_q;
    err       = line_done && ((fill_q != 3'd0) || (pix_nxt != LINE_PIX));

    line_act_nxt = line_act_q;
    if (line_rise)
      line_act_nxt = in_frame_q;
    else if (line_fall)
      line_act_nxt = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++)
        byte_q[i] <= 8'd0;
      fill_q      <= 3'd0;
      pix_cnt_q   <= 16'd0;
      in_line_q   <= 1'b0;
      in_frame_q  <= 1'b0;
      line_act_q  <= 1'b0;
      line_count  <= 16'd0;
      pixel_data  <= 40'd0;
      pixel_valid <= 1'b0;
      line_start  <= 1'b0;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      // Pulses are qualified by enable so a stall never stretches them.
      pixel_valid <= emit;
      line_start  <= enable & line_rise & in_frame_q;
      line_end    <= enable & line_done;
      line_err    <= enable & err;
      frame_start <= enable & frame_rise;
      frame_end   <= enable & frame_fall;
      if (enable) begin
        for (int i = 0; i < 6; i++)
          byte_q[i] <= byte_nxt[i];
        fill_q     <= fill_nxt;
        pix_cnt_q  <= pix_nxt;
        in_line_q  <= in_line;
        in_frame_q <= in_frame;
        line_act_q <= line_act_nxt;
        if (emit)
          pixel_data <= group;
        if (frame_rise)
          line_count <= 16'd0;
        else if (line_done && (line_count != 16'hFFFF))
          line_count <= line_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_csi_rx_raw10_unpacker.sv
// Directed bench for csi_rx_raw10_unpacker with LINE_WIDTH=8 and hand-computed RAW10 groups.
module tb_csi_rx_raw10_unpacker;

  logic        clock, reset_n, enable, payload_valid, in_line, in_frame;
  logic [15:0] payload;
  logic [39:0] pixel_data;
  logic        pixel_valid, line_start, line_end, frame_start, frame_end, line_err;
  logic [15:0] line_count;

  int n_tests = 0;
  int n_fail  = 0;
  int pv_cnt  = 0;
  int pv_mark;

  // bytes 11 22 33 44 E4 and AB 55 66 77 1B and 01 02 03 04 05
  localparam logic [39:0] G1 = {10'h113, 10'h0CE, 10'h089, 10'h044};
  localparam logic [39:0] G2 = {10'h1DC, 10'h199, 10'h156, 10'h2AF};
  localparam logic [39:0] G3 = {10'h010, 10'h00C, 10'h009, 10'h005};

  csi_rx_raw10_unpacker #(.LINE_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable),
    .payload(payload), .payload_valid(payload_valid),
    .in_line(in_line), .in_frame(in_frame),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .line_start(line_start), .line_end(line_end),
    .frame_start(frame_start), .frame_end(frame_end),
    .line_err(line_err), .line_count(line_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) if (pixel_valid) pv_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [15:0] d);
    payload       = d;
    payload_valid = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 0; enable = 1; payload = 0; payload_valid = 0; in_line = 0; in_frame = 0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pv", pixel_valid, 0);
    check("rst_data", pixel_data, 0);
    check("rst_lc", line_count, 0);
    check("rst_pulses", {line_start, line_end, frame_start, frame_end, line_err}, 0);
    reset_n = 1;
    tick();

    // full-length line, two groups
    in_frame = 1; tick();
    check("fs", frame_start, 1);
    in_line = 1; tick();
    check("ls", line_start, 1);
    check("fs_single", frame_start, 0);
    beat(16'h1122); check("b1_pv", pixel_valid, 0);
    beat(16'h3344); check("b2_pv", pixel_valid, 0);
    beat(16'hE4AB); check("g1_pv", pixel_valid, 1); check("g1_data", pixel_data, G1);
    beat(16'h5566); check("b4_pv", pixel_valid, 0);
    beat(16'h771B); check("g2_pv", pixel_valid, 1); check("g2_data", pixel_data, G2);
    payload_valid = 0; tick();
    check("idle_pv", pixel_valid, 0);
    check("hold_data", pixel_data, G2);
    in_line = 0; tick();
    check("l1_end", line_end, 1);
    check("l1_err", line_err, 0);
    check("l1_lc", line_count, 1);

    // short line: one group, leftover byte
    in_line = 1; tick();
    check("l2_ls", line_start, 1);
    beat(16'h0102); beat(16'h0304); beat(16'h0500);
    check("g3_pv", pixel_valid, 1); check("g3_data", pixel_data, G3);
    payload_valid = 0;
    in_line = 0; tick();
    check("l2_end", line_end, 1);
    check("l2_err", line_err, 1);
    check("l2_lc", line_count, 2);
    tick();
    check("l2_end_single", line_end, 0);

    // enable stall mid-line, then simultaneous line/frame fall
    in_line = 1; tick();
    beat(16'h1122);
    enable = 0; payload = 16'hFFFF; payload_valid = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pv", pixel_valid, 0);
      check("stall_pulses", {line_start, line_end, frame_start, frame_end, line_err}, 0);
    end
    enable = 1;
    beat(16'h3344);
    beat(16'hE4AB); check("g4_pv", pixel_valid, 1); check("g4_data", pixel_data, G1);
    beat(16'h5566);
    beat(16'h771B); check("g5_data", pixel_data, G2);
    payload_valid = 0;
    in_line = 0; in_frame = 0; tick();
    check("l3_end", line_end, 1);
    check("l3_fe", frame_end, 1);
    check("l3_err", line_err, 0);
    check("l3_lc", line_count, 3);
    tick();
    check("fe_single", frame_end, 0);
    check("lc_hold", line_count, 3);
    in_frame = 1; tick();
    check("fs2", frame_start, 1);
    check("lc_clr", line_count, 0);

    // line outside a frame is ignored
    in_frame = 0; tick();
    pv_mark = pv_cnt;
    in_line = 1; tick();
    check("nof_ls", line_start, 0);
    beat(16'h1122); beat(16'h3344); beat(16'hE4AB);
    payload_valid = 0;
    in_line = 0; tick();
    check("nof_le", line_end, 0);
    check("nof_pix", pv_cnt - pv_mark, 0);
    check("nof_lc", line_count, 0);

    // reset mid-line, release with line already in progress
    in_frame = 1; tick();
    in_line = 1; tick();
    beat(16'hAAAA); beat(16'hBBBB);
    payload_valid = 0;
    reset_n = 0; #1;
    check("arst_pv", pixel_valid, 0);
    check("arst_data", pixel_data, 0);
    check("arst_lc", line_count, 0);
    tick(); tick();
    reset_n = 1;
    tick();
    check("rel_fs", frame_start, 1);
    check("rel_ls", line_start, 0);
    check("rel_le_err", {line_end, line_err}, 0);
    pv_mark = pv_cnt;
    beat(16'h1122); beat(16'h3344); beat(16'hE4AB);
    payload_valid = 0; tick();
    check("rel_pix", pv_cnt - pv_mark, 0);
    in_line = 0; tick();
    check("rel_le", {line_end, line_err}, 0);
    in_line = 1; tick();
    check("new_ls", line_start, 1);
    beat(16'h1122); beat(16'h3344); beat(16'hE4AB);
    check("new_pv", pixel_valid, 1);
    check("new_data", pixel_data, G1);
    payload_valid = 0; tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
